booth_mult8_issue: RTL and testbench

- Request/response adapter placed around booth_mult8_core.
- Accepts operand requests on a valid/ready stream and buffers them in a small FIFO.
- Drives the core's start/operand/sign_mode inputs one job at a time, captures product on the core's done pulse, and presents the result with its tag on a valid/ready output stream.
- The core is instantiated by the parent; this block only connects to its ports.

---
 rtl/booth_mult8_issue_pkg.sv | 22 ++
 rtl/booth_req_fifo.sv | 66 ++++++
 rtl/booth_mult8_issue.sv | 163 ++++++++++++++++
 tb/tb_booth_mult8_issue.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult8_issue_pkg.sv
// rtl/booth_mult8_issue_pkg.sv - shared FSM states, entry width and log2 helper for the booth issue adapter
package booth_mult8_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic int log2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // One queued request holds {tag, sign_mode, b, a}.
  function automatic int req_entry_w(input int width, input int tag_w);
    return 2 * width + 2 + tag_w;
  endfunction

endpackage

// File: rtl/booth_req_fifo.sv
// rtl/booth_req_fifo.sv - request FIFO with async active-low reset and full/empty/count status
module booth_req_fifo
  import booth_mult8_issue_pkg::*;
#(
  parameter int DW    = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [log2_f(DEPTH):0]   count_o
);

  localparam int AW = log2_f(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push is refused while full even if a pop frees a slot this same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/booth_mult8_issue.sv
// rtl/booth_mult8_issue.sv - valid/ready request/response adapter driving booth_mult8_core one job at a time
// Optional zero-operand bypass enabled by defining BOOTH_ZERO_BYPASS_EN.
module booth_mult8_issue
  import booth_mult8_issue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_sign_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 core_start,
  output logic [WIDTH-1:0]     core_multiplicand,
  output logic [WIDTH-1:0]     core_multiplier,
  output logic [1:0]           core_sign_mode,
  input  logic [2*WIDTH-1:0]   core_product,
  input  logic                 core_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int EW = req_entry_w(WIDTH, TAG_W);
  localparam int AW = log2_f(DEPTH);

  logic [EW-1:0]      push_data, head;
  logic               fifo_full, fifo_empty;
  logic [AW:0]        fifo_count;
  logic [WIDTH-1:0]   head_a, head_b;
  logic [1:0]         head_mode;
  logic [TAG_W-1:0]   head_tag;
  logic               head_zero, load_ok;

  state_e             state_q, state_d;
  logic               fifo_pop, issue_load, bypass_load, capture_core, start_c;

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]         mode_q, mode_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_product_q, out_product_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  assign push_data = {in_tag, in_sign_mode, in_b, in_a};
  assign head_a    = head[WIDTH-1:0];
  assign head_b    = head[2*WIDTH-1:WIDTH];
  assign head_mode = head[2*WIDTH+1:2*WIDTH];
  assign head_tag  = head[EW-1:2*WIDTH+2];

  booth_req_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid && in_ready),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ready = !fifo_full;

`ifdef BOOTH_ZERO_BYPASS_EN
  assign head_zero = (head_a == '0) || (head_b == '0);
`else
  assign head_zero = 1'b0;
`endif

  // A new job may only start once the output register is free or being drained this edge.
  assign load_ok = !fifo_empty && (!out_valid_q || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_ok && !head_zero) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (core_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop     = (state_q == ST_IDLE) && load_ok;
    issue_load   = fifo_pop && !head_zero;
    bypass_load  = fifo_pop && head_zero;
    capture_core = (state_q == ST_WAIT) && core_done;
    start_c      = (state_q == ST_ISSUE);
  end

  always_comb begin
    a_d           = a_q;
    b_d           = b_q;
    mode_d        = mode_q;
    tag_d         = tag_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    out_tag_d     = out_tag_q;
    if (issue_load) begin
      a_d    = head_a;
      b_d    = head_b;
      mode_d = head_mode;
      tag_d  = head_tag;
    end
    if (capture_core) begin
      out_valid_d   = 1'b1;
      out_product_d = core_product;
      out_tag_d     = tag_q;
    end else if (bypass_load) begin
      out_valid_d   = 1'b1;
      out_product_d = '0;
      out_tag_d     = head_tag;
    end else if (out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      mode_q        <= '0;
      tag_q         <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_tag_q     <= '0;
    end else begin
      a_q           <= a_d;
      b_q           <= b_d;
      mode_q        <= mode_d;
      tag_q         <= tag_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_tag_q     <= out_tag_d;
    end
  end

  assign core_start        = start_c;
  assign core_multiplicand = a_q;
  assign core_multiplier   = b_q;
  assign core_sign_mode    = mode_q;
  assign out_valid         = out_valid_q;
  assign out_product       = out_product_q;
  assign out_tag           = out_tag_q;
  assign busy              = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_booth_mult8_issue.sv
// tb/tb_booth_mult8_issue.sv - scoreboard bench for booth_mult8_issue with a behavioural multiplier core
module tb_booth_mult8_issue;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int L_CORE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [1:0]  in_sign_mode = '0;
  logic [3:0]  in_tag = '0;
  logic        core_start;
  logic [7:0]  core_multiplicand, core_multiplier;
  logic [1:0]  core_sign_mode;
  logic [15:0] core_product = '0;
  logic        core_done = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_product;
  logic [3:0]  out_tag;
  logic        busy;

  int n_checks = 0;
  int n_err = 0;
  int n_starts = 0;
  int n_outs = 0;
  int rdy_mode = 1;
  bit spurious_en = 1'b0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  booth_mult8_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sign_mode(in_sign_mode), .in_tag(in_tag),
    .core_start(core_start), .core_multiplicand(core_multiplicand),
    .core_multiplier(core_multiplier), .core_sign_mode(core_sign_mode),
    .core_product(core_product), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag), .busy(busy)
  );

  function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    int av, bv;
    av = m[1] ? int'($signed(a)) : int'(a);
    bv = m[0] ? int'($signed(b)) : int'(b);
    return 16'(av * bv);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Behavioural core: fixed latency, product from plain integer arithmetic.
  initial begin
    int cnt;
    logic [7:0] ca, cb;
    logic [1:0] cm;
    cnt = 0; ca = '0; cb = '0; cm = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0; core_done = 1'b0; core_product = '0;
      end else begin
        core_done = 1'b0;
        if (core_start) begin
          n_starts++;
          chk("start_while_busy", 32'(cnt), 32'd0);
          ca = core_multiplicand; cb = core_multiplier; cm = core_sign_mode;
          cnt = L_CORE;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            core_done = 1'b1;
            core_product = ref_mult(ca, cb, cm);
          end
        end else if (spurious_en && $urandom_range(0, 5) == 0) begin
          core_done = 1'b1;
          core_product = 16'($urandom);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted result and checks hold-under-stall.
  initial begin
    bit stall;
    logic [15:0] sp;
    logic [3:0] st;
    logic [19:0] e;
    stall = 1'b0; sp = '0; st = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) chk("hold_stable", {11'd0, out_valid, out_product, out_tag}, {11'd0, 1'b1, sp, st});
        if (out_valid && out_ready) begin
          n_outs++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: got product %0h tag %0d, required no result", out_product, out_tag);
          end else begin
            e = exp_q.pop_front();
            if ({out_product, out_tag} !== e) begin
              n_err++;
              $display("FAIL result: got product %0h tag %0d, required product %0h tag %0d",
                       out_product, out_tag, e[19:4], e[3:0]);
            end
          end
        end
        stall = out_valid && !out_ready;
        sp = out_product; st = out_tag;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                      input logic [3:0] t, input logic [15:0] expv);
    int w;
    w = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sign_mode = m; in_tag = t;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({expv, t});
        break;
      end
      w++;
      if (w > 300) begin
        chk("push_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_rand(input logic [3:0] t, input bit allow_zero);
    logic [7:0] a, b;
    logic [1:0] m;
    a = 8'($urandom); b = 8'($urandom); m = 2'($urandom);
    if (allow_zero && $urandom_range(0, 4) == 0) a = '0;
    if (allow_zero && $urandom_range(0, 4) == 0) b = '0;
    if (!allow_zero && a == 0) a = 8'h11;
    if (!allow_zero && b == 0) b = 8'h22;
    push(a, b, m, t, ref_mult(a, b, m));
  endtask

  task automatic set_rdy(input int m);
    @(negedge clk); rdy_mode = m;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_out_valid();
    int w;
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk); w++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, o0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_out_product", 32'(out_product), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    s0 = n_starts;
    push(8'hFD, 8'h05, 2'b11, 4'd3, 16'hFFF1);
    drain();
    chk("ss_start_count", 32'(n_starts - s0), 32'd1);

    push(8'hFF, 8'hFF, 2'b00, 4'd1, 16'hFE01);
    push(8'h80, 8'hFF, 2'b10, 4'd2, 16'h8080);
    drain();

    set_rdy(0);
    for (int t = 0; t < 5; t++) push_rand(4'(t), 1'b0);
    fork
      push_rand(4'd5, 1'b0);
      begin
        wait_out_valid();
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_first_tag", 32'(out_tag), 32'd0);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        rdy_mode = 1;
      end
    join
    drain();

    set_rdy(0);
    for (int t = 6; t < 11; t++) push_rand(4'(t), 1'b0);
    wait_out_valid();
    chk("full_before_pp", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    fork
      push_rand(4'd11, 1'b0);
      begin
        @(negedge clk); rdy_mode = 1;
        @(negedge clk); rdy_mode = 0;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    chk("full_after_pp", 32'(in_ready), 32'd0);
    set_rdy(2);
    drain();

    set_rdy(1);
    s0 = n_starts;
    push_rand(4'd12, 1'b0);
    begin
      int w;
      w = 0;
      while (!core_start && w < 50) begin
        @(negedge clk); w++;
      end
    end
    chk("rst_saw_start", 32'(core_start), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    o0 = n_outs;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_result", 32'(n_outs - o0), 32'd0);
    chk("midrst_starts", 32'(n_starts - s0), 32'd1);

    s0 = n_starts;
    push(8'h00, 8'h7F, 2'b11, 4'd9, 16'h0000);
    drain();
`ifdef BOOTH_ZERO_BYPASS_EN
    chk("zero_start_count", 32'(n_starts - s0), 32'd0);
`else
    chk("zero_start_count", 32'(n_starts - s0), 32'd1);
`endif

    set_rdy(2);
    spurious_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      push_rand(4'(i), 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    spurious_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
